// File: rtl/graph_bfs_path.sv
`default_nettype none
// ============================================================================
// Module  : graph_bfs_path
// Purpose : Level-synchronous BFS over an external edge RAM; returns the
//           shortest unmasked path from startPose to endPose as an edge bitmask.
// Revision: 1.0
// ============================================================================
module graph_bfs_path #(
    parameter int NUM_POSE  = 66,
    parameter int NUM_EDGE  = 1034,
    parameter int POSE_W    = 8,
    parameter int EDGE_W    = 11,
    parameter int MAX_LEVEL = 10,
    parameter int LEVEL_W   = 4
) (
    input  logic                CLK,
    input  logic                RST_n,
    input  logic                start,
    input  logic [POSE_W-1:0]   startPose,
    input  logic [POSE_W-1:0]   endPose,
    input  logic [NUM_EDGE-1:0] edgeMask,
    output logic [EDGE_W-1:0]   ramAddress,
    input  logic [2*POSE_W-1:0] RAMData,
    output logic                busy,
    output logic                done,
    output logic                found,
    output logic [LEVEL_W-1:0]  pathLen,
    output logic [NUM_EDGE-1:0] selectEdge,
    output logic [2:0]          state
);

    localparam int CNT_W = EDGE_W + 1;
    localparam logic [POSE_W:0]    C_NUM_POSE = (POSE_W+1)'(NUM_POSE);
    localparam logic [CNT_W-1:0]   C_NUM_EDGE = CNT_W'(NUM_EDGE);
    localparam logic [EDGE_W-1:0]  C_LAST_EDGE = EDGE_W'(NUM_EDGE - 1);
    localparam logic [LEVEL_W-1:0] C_MAX_LEVEL = LEVEL_W'(MAX_LEVEL);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_F_INIT  = 3'd1,
        S_F_SWEEP = 3'd2,
        S_F_CHECK = 3'd3,
        S_B_READ  = 3'd4,
        S_B_WAIT  = 3'd5,
        S_DONE    = 3'd6,
        S_FAIL    = 3'd7
    } state_t;

    state_t                state_q;
    logic [POSE_W-1:0]     start_q, end_q, cur_q;
    logic [NUM_EDGE-1:0]   mask_q, sel_q;
    logic [NUM_POSE-1:0]   visited_q, snap_q;
    logic [EDGE_W-1:0]     parent_q [NUM_POSE];
    logic [EDGE_W-1:0]     addr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [LEVEL_W-1:0]    level_q, len_q;
    logic                  added_q, busy_q, done_q, found_q;

    logic [POSE_W-1:0]     w_pa, w_pb, w_p, w_nxt;
    logic [NUM_POSE-1:0]   w_oh_a, w_oh_b, w_oh_p, w_oh_end, w_oh_start;
    logic [NUM_EDGE-1:0]   w_oh_e, w_oh_addr;
    logic [EDGE_W-1:0]     w_edge, w_par_end, w_par_nxt;
    logic [LEVEL_W-1:0]    w_level_inc;
    logic                  w_snap_a, w_snap_b, w_pa_ok, w_pb_ok, w_qualify;
    logic                  w_start_ok, w_end_ok, w_vis_end;

    assign w_pa       = RAMData[2*POSE_W-1:POSE_W];
    assign w_pb       = RAMData[POSE_W-1:0];
    assign w_edge     = EDGE_W'(cnt_q - CNT_W'(1));
    assign w_oh_e     = NUM_EDGE'(1) << w_edge;
    assign w_oh_addr  = NUM_EDGE'(1) << addr_q;
    assign w_oh_a     = NUM_POSE'(1) << w_pa;
    assign w_oh_b     = NUM_POSE'(1) << w_pb;
    assign w_oh_end   = NUM_POSE'(1) << end_q;
    assign w_oh_start = NUM_POSE'(1) << start_q;
    assign w_snap_a   = |(snap_q & w_oh_a);
    assign w_snap_b   = |(snap_q & w_oh_b);
    assign w_p        = w_snap_a ? w_pb : w_pa;
    assign w_oh_p     = NUM_POSE'(1) << w_p;
    assign w_pa_ok    = {1'b0, w_pa} < C_NUM_POSE;
    assign w_pb_ok    = {1'b0, w_pb} < C_NUM_POSE;
    assign w_start_ok = {1'b0, start_q} < C_NUM_POSE;
    assign w_end_ok   = {1'b0, end_q} < C_NUM_POSE;
    assign w_vis_end  = |(visited_q & w_oh_end);
    assign w_nxt      = (w_pa == cur_q) ? w_pb : w_pa;
    assign w_level_inc = (level_q == C_MAX_LEVEL) ? level_q : level_q + LEVEL_W'(1);

    // cnt_q == 0 is the first sweep cycle, where no RAM data is pending yet
    assign w_qualify = (cnt_q != '0) && !(|(mask_q & w_oh_e)) && w_pa_ok && w_pb_ok &&
                       (w_pa != w_pb) && (w_snap_a ^ w_snap_b) && !(|(visited_q & w_oh_p));

    always_comb begin
        w_par_end = '0;
        w_par_nxt = '0;
        for (int i = 0; i < NUM_POSE; i++) begin
            if (end_q == POSE_W'(i)) w_par_end = parent_q[i];
            if (w_nxt == POSE_W'(i)) w_par_nxt = parent_q[i];
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= S_IDLE;
            start_q   <= '0;
            end_q     <= '0;
            cur_q     <= '0;
            mask_q    <= '0;
            sel_q     <= '0;
            visited_q <= '0;
            snap_q    <= '0;
            parent_q  <= '{default: '0};
            addr_q    <= '0;
            cnt_q     <= '0;
            level_q   <= '0;
            len_q     <= '0;
            added_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        start_q   <= startPose;
                        end_q     <= endPose;
                        mask_q    <= edgeMask;
                        sel_q     <= '0;
                        len_q     <= '0;
                        found_q   <= 1'b0;
                        visited_q <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        state_q   <= S_F_INIT;
                    end
                end
                S_F_INIT: begin
                    if (!w_start_ok || !w_end_ok) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FAIL;
                    end else if (start_q == end_q) begin
                        found_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        visited_q <= w_oh_start;
                        snap_q    <= w_oh_start;
                        level_q   <= '0;
                        cnt_q     <= '0;
                        addr_q    <= '0;
                        added_q   <= 1'b0;
                        state_q   <= S_F_SWEEP;
                    end
                end
                S_F_SWEEP: begin
                    if (addr_q != C_LAST_EDGE) addr_q <= addr_q + EDGE_W'(1);
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (w_qualify) begin
                        visited_q <= visited_q | w_oh_p;
                        added_q   <= 1'b1;
                        for (int i = 0; i < NUM_POSE; i++) begin
                            if (w_oh_p[i]) parent_q[i] <= w_edge;
                        end
                    end
                    if (cnt_q == C_NUM_EDGE) state_q <= S_F_CHECK;
                end
                S_F_CHECK: begin
                    level_q <= w_level_inc;
                    if (w_vis_end) begin
                        cur_q   <= end_q;
                        addr_q  <= w_par_end;
                        len_q   <= w_level_inc;
                        state_q <= S_B_READ;
                    end else if (!added_q || (w_level_inc == C_MAX_LEVEL)) begin
                        sel_q   <= '0;
                        len_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FAIL;
                    end else begin
                        snap_q  <= visited_q;
                        cnt_q   <= '0;
                        addr_q  <= '0;
                        added_q <= 1'b0;
                        state_q <= S_F_SWEEP;
                    end
                end
                S_B_READ: state_q <= S_B_WAIT;
                S_B_WAIT: begin
                    // addr_q holds parent[cur]; RAMData now carries that edge's endpoints
                    sel_q <= sel_q | w_oh_addr;
                    cur_q <= w_nxt;
                    if (w_nxt == start_q) begin
                        found_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        addr_q  <= w_par_nxt;
                        state_q <= S_B_READ;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ramAddress = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign found      = found_q;
    assign pathLen    = len_q;
    assign selectEdge = sel_q;
    assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_graph_bfs_path.sv
`default_nettype none
// ============================================================================
// Module  : tb_graph_bfs_path
// Purpose : Scoreboard bench for graph_bfs_path on an 8-pose / 8-edge graph.
// Revision: 1.0
// ============================================================================
module tb_graph_bfs_path;

    localparam int NP = 8;
    localparam int NE = 8;
    localparam int PW = 4;
    localparam int EW = 3;
    localparam int ML = 4;
    localparam int LW = 3;

    logic          CLK = 1'b0;
    logic          RST_n = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] startPose = '0;
    logic [PW-1:0] endPose = '0;
    logic [NE-1:0] edgeMask = '0;
    logic [EW-1:0] ramAddress;
    logic [2*PW-1:0] RAMData;
    logic          busy, done, found;
    logic [LW-1:0] pathLen;
    logic [NE-1:0] selectEdge;
    logic [2:0]    state;

    logic [2*PW-1:0] ram [NE];

    typedef struct packed {
        logic [2:0]    st;
        logic          bsy;
        logic          fnd;
        logic [LW-1:0] len;
        logic [NE-1:0] sel;
    } res_t;

    typedef struct {
        res_t r;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    graph_bfs_path #(
        .NUM_POSE(NP), .NUM_EDGE(NE), .POSE_W(PW), .EDGE_W(EW), .MAX_LEVEL(ML), .LEVEL_W(LW)
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .start(start), .startPose(startPose), .endPose(endPose),
        .edgeMask(edgeMask), .ramAddress(ramAddress), .RAMData(RAMData), .busy(busy),
        .done(done), .found(found), .pathLen(pathLen), .selectEdge(selectEdge), .state(state)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) RAMData <= ram[ramAddress];

    task automatic load_ram(input logic [NE-1:0][2*PW-1:0] g);
        for (int i = 0; i < NE; i++) ram[i] = g[i];
    endtask

    // Push the expectation, pulse start, then wait (bounded) for done.
    // Cycle count: the cycle carrying start is 0.
    task automatic launch(input string name, input logic [PW-1:0] s, input logic [PW-1:0] e,
                          input logic [NE-1:0] m, input res_t r, input int cyc,
                          input int glitch, output int got);
        exp_t x;
        x.r = r;
        x.cyc = cyc;
        sb.push_back(x);
        @(negedge CLK);
        startPose = s; endPose = e; edgeMask = m; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        got = 1;
        while (done !== 1'b1 && got < 200) begin
            if (got == glitch) begin
                startPose = 4'd1; endPose = 4'd1; edgeMask = '1; start = 1'b1;
            end
            @(posedge CLK); #1;
            start = 1'b0;
            got++;
        end
        if (done !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, done, got);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset.state got %0d exp 0", state); end
        n_checks++; if (ramAddress !== '0) begin n_fail++; $display("FAIL reset.ramAddress got %0d exp 0", ramAddress); end
        n_checks++; if ({busy, done, found} !== 3'b000) begin n_fail++; $display("FAIL reset.flags got %b exp 000", {busy, done, found}); end
        n_checks++; if (pathLen !== '0) begin n_fail++; $display("FAIL reset.pathLen got %0d exp 0", pathLen); end
        n_checks++; if (selectEdge !== '0) begin n_fail++; $display("FAIL reset.selectEdge got %h exp 00", selectEdge); end
        @(negedge CLK);
        RST_n = 1'b1;
    endtask

    // Runs one job from a table row and compares result and latency.
    task automatic run_row(input string name, input logic [PW-1:0] s, input logic [PW-1:0] e,
                           input logic [NE-1:0] m, input res_t r, input int cyc, input int glitch);
        int   c;
        exp_t x;
        launch(name, s, e, m, r, cyc, glitch, c);
        x = sb.pop_front();
        n_checks++;
        if ({state, busy, found, pathLen, selectEdge} !== x.r) begin
            n_fail++;
            $display("FAIL %s result {state,busy,found,len,sel}: got %h exp %h", name,
                     {state, busy, found, pathLen, selectEdge}, x.r);
        end
        n_checks++;
        if (c != x.cyc) begin
            n_fail++;
            $display("FAIL %s latency: got %0d exp %0d", name, c, x.cyc);
        end
    endtask

    task automatic test_chain();
        load_ram({8'h77, 8'h77, 8'h77, 8'h77, 8'h94, 8'h23, 8'h12, 8'h01});
        run_row("chain", 4'd0, 4'd3, 8'h00, {3'd6, 1'b0, 1'b1, 3'd3, 8'h07}, 38, -1);
    endtask

    task automatic test_square();
        load_ram({8'h77, 8'h77, 8'h77, 8'h77, 8'h32, 8'h02, 8'h13, 8'h01});
        run_row("square_masked", 4'd0, 4'd3, 8'h02, {3'd6, 1'b0, 1'b1, 3'd2, 8'h0C}, 26, -1);
        run_row("square_open",   4'd0, 4'd3, 8'h00, {3'd6, 1'b0, 1'b1, 3'd2, 8'h03}, 26, -1);
    endtask

    task automatic test_fail();
        run_row("unreachable", 4'd0, 4'd5,  8'h00, {3'd7, 1'b0, 1'b0, 3'd0, 8'h00}, 32, -1);
        run_row("bad_start",   4'd9, 4'd3,  8'h00, {3'd7, 1'b0, 1'b0, 3'd0, 8'h00}, 2, -1);
        run_row("bad_end",     4'd0, 4'd12, 8'h00, {3'd7, 1'b0, 1'b0, 3'd0, 8'h00}, 2, -1);
    endtask

    task automatic test_max_level();
        load_ram({8'h77, 8'h77, 8'h56, 8'h45, 8'h43, 8'h23, 8'h21, 8'h01});
        run_row("too_deep",  4'd0, 4'd6, 8'h00, {3'd7, 1'b0, 1'b0, 3'd0, 8'h00}, 42, -1);
        run_row("max_depth", 4'd0, 4'd4, 8'h00, {3'd6, 1'b0, 1'b1, 3'd4, 8'h0F}, 50, -1);
        run_row("same_pose", 4'd2, 4'd2, 8'h00, {3'd6, 1'b0, 1'b1, 3'd0, 8'h00}, 2, -1);
    endtask

    task automatic test_ignore_start();
        load_ram({8'h77, 8'h77, 8'h77, 8'h77, 8'h94, 8'h23, 8'h12, 8'h01});
        run_row("start_in_sweep", 4'd0, 4'd3, 8'h00, {3'd6, 1'b0, 1'b1, 3'd3, 8'h07}, 38, 5);
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        startPose = 4'd0; endPose = 4'd3; edgeMask = '0; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        RST_n = 1'b0;
        #1;
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL midreset.state got %0d exp 0", state); end
        n_checks++; if (ramAddress !== '0) begin n_fail++; $display("FAIL midreset.ramAddress got %0d exp 0", ramAddress); end
        n_checks++; if ({busy, done, found} !== 3'b000) begin n_fail++; $display("FAIL midreset.flags got %b exp 000", {busy, done, found}); end
        n_checks++; if ({pathLen, selectEdge} !== '0) begin n_fail++; $display("FAIL midreset.len_sel got %h exp 0", {pathLen, selectEdge}); end
        @(negedge CLK);
        RST_n = 1'b1;
        run_row("after_reset", 4'd0, 4'd3, 8'h00, {3'd6, 1'b0, 1'b1, 3'd3, 8'h07}, 38, -1);
    endtask

    initial begin
        for (int i = 0; i < NE; i++) ram[i] = 8'h77;
        test_reset();
        test_chain();
        test_square();
        test_fail();
        test_max_level();
        test_ignore_start();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard leftover: got %0d entries exp 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
